axi_rd_arbiter: RTL and testbench

//  Shares the core's single AXI3 read-address/read-data channel pair between the instruction-fetch

---
 rtl/axi_rd_arbiter.sv | 164 ++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// AXI3 read-channel arbiter: shares one AR/R pair between the instruction-fetch (I) and
// data/load (D) requesters, tagging each burst with a per-side ARID and routing R beats by RID.
module axi_rd_arbiter #(
  parameter logic [3:0] I_ID      = 4'd0,
  parameter logic [3:0] D_ID      = 4'd1,
  parameter bit         PRIO_MODE = 1'b0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_len,
  input  logic [2:0]  i_size,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic        i_rlast,
  output logic        i_rerr,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [7:0]  d_len,
  input  logic [2:0]  d_size,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_rlast,
  output logic        d_rerr,
  output logic [31:0] d_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARQ  = 2'd1,
    ST_RDAT = 2'd2
  } side_st_e;

  side_st_e    i_st;
  side_st_e    d_st;
  logic        rr_ptr;
  logic        side_p1;
  logic        vld_p1;
  logic [3:0]  id_p1;
  logic [31:0] addr_p1;
  logic [7:0]  len_p1;
  logic [2:0]  size_p1;

  logic slot_free;
  logic ar_hs;
  logic i_elig;
  logic d_elig;
  logic contest;
  logic pick_d;
  logic any_gnt;
  logic i_hit;
  logic d_hit;

  assign rready    = 1'b1;
  assign ar_hs     = vld_p1 && arready;
  assign slot_free = !vld_p1 || arready;
  assign i_elig    = i_req && (i_st == ST_IDLE);
  assign d_elig    = d_req && (d_st == ST_IDLE);
  assign contest   = i_elig && d_elig;

  // rr_ptr: 0 means I wins the next tie, 1 means D wins it
  always_comb begin
    pick_d = d_elig;
    if (contest) begin
      pick_d = PRIO_MODE ? 1'b1 : rr_ptr;
    end
  end

  // Grants are masked during reset so a held request cannot leak a grant out
  assign any_gnt = aresetn && slot_free && (i_elig || d_elig);
  assign i_gnt   = any_gnt && !pick_d;
  assign d_gnt   = any_gnt && pick_d;

  // Stage p1: the single AR slot, held stable until the slave takes it
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p1  <= 1'b0;
      side_p1 <= 1'b0;
      id_p1   <= 4'd0;
      addr_p1 <= 32'd0;
      len_p1  <= 8'd0;
      size_p1 <= 3'd0;
      rr_ptr  <= 1'b0;
    end else begin
      if (any_gnt) begin
        vld_p1  <= 1'b1;
        side_p1 <= pick_d;
        id_p1   <= pick_d ? D_ID   : I_ID;
        addr_p1 <= pick_d ? d_addr : i_addr;
        len_p1  <= pick_d ? d_len  : i_len;
        size_p1 <= pick_d ? d_size : i_size;
      end else if (ar_hs) begin
        vld_p1 <= 1'b0;
      end
      if (any_gnt && contest) begin
        rr_ptr <= !rr_ptr;
      end
    end
  end

  assign arvalid = vld_p1;
  assign arid    = id_p1;
  assign araddr  = addr_p1;
  assign arlen   = len_p1;
  assign arsize  = size_p1;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign i_hit = rvalid && (rid == I_ID);
  assign d_hit = rvalid && (rid == D_ID);

  // Per-side burst trackers; side_p1 tells whose AR the handshake belongs to
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      i_st <= ST_IDLE;
      d_st <= ST_IDLE;
    end else begin
      case (i_st)
        ST_IDLE: if (i_gnt) i_st <= ST_ARQ;
        ST_ARQ:  if (ar_hs && !side_p1) i_st <= ST_RDAT;
        ST_RDAT: if (i_hit && rready && rlast) i_st <= ST_IDLE;
        default: i_st <= ST_IDLE;
      endcase
      case (d_st)
        ST_IDLE: if (d_gnt) d_st <= ST_ARQ;
        ST_ARQ:  if (ar_hs && side_p1) d_st <= ST_RDAT;
        ST_RDAT: if (d_hit && rready && rlast) d_st <= ST_IDLE;
        default: d_st <= ST_IDLE;
      endcase
    end
  end

  // R beats are steered combinationally; unknown RIDs are sunk without effect
  assign i_rvalid = aresetn && i_hit;
  assign i_rdata  = rdata;
  assign i_rlast  = i_rvalid && rlast;
  assign i_rerr   = i_rvalid && (rresp != 2'b00);

  assign d_rvalid = aresetn && d_hit;
  assign d_rdata  = rdata;
  assign d_rlast  = d_rvalid && rlast;
  assign d_rerr   = d_rvalid && (rresp != 2'b00);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a round-robin instance carries most scenarios, a
// fixed-priority instance with its own request lines covers the D-wins tie-break.
module tb_axi_rd_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        i_req, d_req, p_i_req, p_d_req;
  logic [31:0] i_addr, d_addr;
  logic [7:0]  i_len, d_len;
  logic [2:0]  i_size, d_size;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;

  logic        i_gnt, i_rvalid, i_rlast, i_rerr, d_gnt, d_rvalid, d_rlast, d_rerr;
  logic [31:0] i_rdata, d_rdata, araddr;
  logic [3:0]  arid, arcache;
  logic [7:0]  arlen;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, rready;

  logic        f_i_gnt, f_i_rvalid, f_i_rlast, f_i_rerr, f_d_gnt, f_d_rvalid, f_d_rlast, f_d_rerr;
  logic [31:0] f_i_rdata, f_d_rdata, f_araddr;
  logic [3:0]  f_arid, f_arcache;
  logic [7:0]  f_arlen;
  logic [2:0]  f_arsize, f_arprot;
  logic [1:0]  f_arburst, f_arlock;
  logic        f_arvalid, f_rready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 aclk = ~aclk;

  axi_rd_arbiter #(.I_ID(4'd0), .D_ID(4'd1), .PRIO_MODE(1'b0)) u_rr (
    .aclk(aclk), .aresetn(aresetn),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_size(i_size), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rerr(i_rerr), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_size(d_size), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rerr(d_rerr), .d_rdata(d_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  axi_rd_arbiter #(.I_ID(4'd0), .D_ID(4'd1), .PRIO_MODE(1'b1)) u_fp (
    .aclk(aclk), .aresetn(aresetn),
    .i_req(p_i_req), .i_addr(i_addr), .i_len(i_len), .i_size(i_size), .i_gnt(f_i_gnt),
    .i_rvalid(f_i_rvalid), .i_rlast(f_i_rlast), .i_rerr(f_i_rerr), .i_rdata(f_i_rdata),
    .d_req(p_d_req), .d_addr(d_addr), .d_len(d_len), .d_size(d_size), .d_gnt(f_d_gnt),
    .d_rvalid(f_d_rvalid), .d_rlast(f_d_rlast), .d_rerr(f_d_rerr), .d_rdata(f_d_rdata),
    .arid(f_arid), .araddr(f_araddr), .arlen(f_arlen), .arsize(f_arsize), .arburst(f_arburst),
    .arlock(f_arlock), .arcache(f_arcache), .arprot(f_arprot), .arvalid(f_arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(f_rready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] data, input logic last,
                        input logic [1:0] resp);
    rvalid = 1'b1;
    rid    = id;
    rdata  = data;
    rlast  = last;
    rresp  = resp;
  endtask

  task automatic r_idle();
    rvalid = 1'b0;
    rid    = 4'd0;
    rdata  = 32'd0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    i_req = 1'b0; d_req = 1'b0; p_i_req = 1'b0; p_d_req = 1'b0;
    arready = 1'b0;
    r_idle();
    step();
    step();
    aresetn = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the end of the stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    i_req = 1'b1; d_req = 1'b0; p_i_req = 1'b0; p_d_req = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; i_len = 8'd0; d_len = 8'd0;
    i_size = 3'd2; d_size = 3'd2;
    arready = 1'b0;
    r_idle();

    // reset state, with a request and an R beat present during reset
    step();
    r_beat(4'd0, 32'h1234_5678, 1'b1, 2'b00);
    settle();
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_i_gnt", 32'(i_gnt), 32'd0);
    check("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    check("rst_rready", 32'(rready), 32'd1);
    check("rst_araddr", araddr, 32'd0);
    check("rst_arid", 32'(arid), 32'd0);
    r_idle();
    i_req = 1'b0;
    step();
    aresetn = 1'b1;
    step();

    // single I burst of 4 beats
    i_req = 1'b1; i_addr = 32'h1C00_0000; i_len = 8'd3; i_size = 3'd2;
    settle();
    check("t1_i_gnt", 32'(i_gnt), 32'd1);
    check("t1_d_gnt", 32'(d_gnt), 32'd0);
    check("t1_arvalid_pre", 32'(arvalid), 32'd0);
    step();
    i_req = 1'b0;
    settle();
    check("t1_arvalid", 32'(arvalid), 32'd1);
    check("t1_arid", 32'(arid), 32'd0);
    check("t1_araddr", araddr, 32'h1C00_0000);
    check("t1_arlen", 32'(arlen), 32'd3);
    check("t1_arsize", 32'(arsize), 32'd2);
    check("t1_arburst", 32'(arburst), 32'd1);
    arready = 1'b1;
    step();
    arready = 1'b0;
    settle();
    check("t1_ar_done", 32'(arvalid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      r_beat(4'd0, 32'hA000_0000 + k, (k == 3), 2'b00);
      settle();
      check("t1_i_rvalid", 32'(i_rvalid), 32'd1);
      check("t1_i_rdata", i_rdata, 32'hA000_0000 + k);
      check("t1_i_rlast", 32'(i_rlast), 32'(k == 3));
      check("t1_d_rvalid", 32'(d_rvalid), 32'd0);
      step();
    end
    r_idle();
    i_req = 1'b1; i_addr = 32'h1C00_0020; i_len = 8'd0;
    settle();
    check("t1_idle_regrant", 32'(i_gnt), 32'd1);
    step();
    i_req = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    r_beat(4'd0, 32'h5, 1'b1, 2'b00);
    step();
    r_idle();

    // round-robin tie-break from a fresh reset
    do_reset();
    i_req = 1'b1; i_addr = 32'h1C00_0100; i_len = 8'd1;
    d_req = 1'b1; d_addr = 32'h2000_0000; d_len = 8'd1;
    settle();
    check("t2_rr_i_first", 32'(i_gnt), 32'd1);
    check("t2_rr_d_held", 32'(d_gnt), 32'd0);
    step();
    i_req = 1'b0;
    settle();
    check("t2_slot_busy", 32'(d_gnt), 32'd0);
    arready = 1'b1;
    settle();
    check("t2_d_b2b_gnt", 32'(d_gnt), 32'd1);
    step();
    d_req = 1'b0;
    settle();
    check("t2_d_arid", 32'(arid), 32'd1);
    check("t2_d_araddr", araddr, 32'h2000_0000);
    check("t2_d_arvalid", 32'(arvalid), 32'd1);
    step();
    arready = 1'b0;
    r_beat(4'd0, 32'h1, 1'b1, 2'b00);
    step();
    r_beat(4'd1, 32'h2, 1'b1, 2'b00);
    step();
    r_idle();
    i_req = 1'b1; d_req = 1'b1;
    settle();
    check("t2_rr_d_first", 32'(d_gnt), 32'd1);
    check("t2_rr_i_held", 32'(i_gnt), 32'd0);
    step();
    d_req = 1'b0;
    arready = 1'b1;
    settle();
    check("t2_rr_i_next", 32'(i_gnt), 32'd1);
    step();
    i_req = 1'b0;
    step();
    arready = 1'b0;

    // both sides in RDAT: interleaved beats and a stray RID
    r_beat(4'd0, 32'h0000_0011, 1'b0, 2'b00);
    settle();
    check("t4_i_beat_i", 32'(i_rvalid), 32'd1);
    check("t4_i_beat_d", 32'(d_rvalid), 32'd0);
    check("t4_i_data", i_rdata, 32'h0000_0011);
    step();
    r_beat(4'd1, 32'h0000_0022, 1'b0, 2'b00);
    settle();
    check("t4_d_beat_d", 32'(d_rvalid), 32'd1);
    check("t4_d_beat_i", 32'(i_rvalid), 32'd0);
    check("t4_d_data", d_rdata, 32'h0000_0022);
    step();
    r_beat(4'd5, 32'h0000_0055, 1'b1, 2'b00);
    settle();
    check("t4_stray_i", 32'(i_rvalid), 32'd0);
    check("t4_stray_d", 32'(d_rvalid), 32'd0);
    step();
    r_beat(4'd0, 32'h0000_0033, 1'b1, 2'b00);
    settle();
    check("t4_i_last", 32'(i_rlast), 32'd1);
    check("t4_i_last_d", 32'(d_rvalid), 32'd0);
    step();
    r_beat(4'd1, 32'h0000_0044, 1'b1, 2'b00);
    settle();
    check("t4_d_last", 32'(d_rlast), 32'd1);
    step();
    r_idle();

    // AR held under back-pressure
    i_req = 1'b1; i_addr = 32'h1C00_0040; i_len = 8'd7;
    settle();
    check("t3_i_gnt", 32'(i_gnt), 32'd1);
    step();
    i_req = 1'b0;
    d_req = 1'b1; d_addr = 32'h2000_0200; d_len = 8'd1;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("t3_hold_arvalid", 32'(arvalid), 32'd1);
      check("t3_hold_araddr", araddr, 32'h1C00_0040);
      check("t3_hold_arlen", 32'(arlen), 32'd7);
      check("t3_hold_arid", 32'(arid), 32'd0);
      check("t3_no_d_gnt", 32'(d_gnt), 32'd0);
      step();
    end
    arready = 1'b1;
    settle();
    check("t3_d_gnt_on_ready", 32'(d_gnt), 32'd1);
    step();
    d_req = 1'b0;
    settle();
    check("t3_d_arid", 32'(arid), 32'd1);
    check("t3_d_araddr", araddr, 32'h2000_0200);
    step();
    arready = 1'b0;
    r_beat(4'd0, 32'h7, 1'b1, 2'b00);
    step();
    r_beat(4'd1, 32'h8, 1'b1, 2'b00);
    step();
    r_idle();

    // error response mid-burst, and rlast coinciding with a new request
    i_req = 1'b1; i_addr = 32'h1C00_0080; i_len = 8'd3;
    settle();
    check("t5_i_gnt", 32'(i_gnt), 32'd1);
    step();
    i_req = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r_beat(4'd0, 32'h0000_00B0 + k, (k == 3), (k == 1) ? 2'b10 : 2'b00);
      if (k == 3) i_req = 1'b1;
      settle();
      check("t5_i_rvalid", 32'(i_rvalid), 32'd1);
      check("t5_i_rerr", 32'(i_rerr), 32'(k == 1));
      check("t5_i_rlast", 32'(i_rlast), 32'(k == 3));
      if (k == 3) check("t5_no_gnt_at_rlast", 32'(i_gnt), 32'd0);
      step();
    end
    r_idle();
    settle();
    check("t5_gnt_after_rlast", 32'(i_gnt), 32'd1);
    step();
    i_req = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    r_beat(4'd0, 32'h9, 1'b1, 2'b00);
    step();
    r_idle();

    // reset asserted mid-burst: D in RDAT, I's AR pending
    d_req = 1'b1; d_addr = 32'h2000_0100; d_len = 8'd3;
    settle();
    check("t6_d_gnt", 32'(d_gnt), 32'd1);
    step();
    d_req = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    i_req = 1'b1;
    settle();
    check("t6_i_gnt", 32'(i_gnt), 32'd1);
    step();
    i_req = 1'b0;
    r_beat(4'd1, 32'h0000_00D0, 1'b0, 2'b00);
    i_req = 1'b1; d_req = 1'b1;
    settle();
    check("t6_arvalid_pre", 32'(arvalid), 32'd1);
    check("t6_d_rvalid_pre", 32'(d_rvalid), 32'd1);
    aresetn = 1'b0;
    settle();
    check("t6_rst_arvalid", 32'(arvalid), 32'd0);
    check("t6_rst_i_gnt", 32'(i_gnt), 32'd0);
    check("t6_rst_d_gnt", 32'(d_gnt), 32'd0);
    check("t6_rst_d_rvalid", 32'(d_rvalid), 32'd0);
    r_idle();
    i_req = 1'b0; d_req = 1'b0;
    step();
    aresetn = 1'b1;
    settle();
    d_req = 1'b1;
    settle();
    check("t6_regrant_d", 32'(d_gnt), 32'd1);
    check("t6_regrant_i", 32'(i_gnt), 32'd0);
    step();
    d_req = 1'b0;
    settle();
    check("t6_arvalid_post", 32'(arvalid), 32'd1);
    check("t6_arid_post", 32'(arid), 32'd1);
    check("t6_araddr_post", araddr, 32'h2000_0100);

    // fixed-priority instance: D wins every tie
    do_reset();
    p_i_req = 1'b1; p_d_req = 1'b1;
    i_addr = 32'h1C00_0300; d_addr = 32'h2000_0300;
    settle();
    check("t2_fp_d_first", 32'(f_d_gnt), 32'd1);
    check("t2_fp_i_held", 32'(f_i_gnt), 32'd0);
    step();
    p_d_req = 1'b0;
    settle();
    check("t2_fp_slot_busy", 32'(f_i_gnt), 32'd0);
    check("t2_fp_d_arid", 32'(f_arid), 32'd1);
    arready = 1'b1;
    settle();
    check("t2_fp_i_next", 32'(f_i_gnt), 32'd1);
    step();
    p_i_req = 1'b0;
    settle();
    check("t2_fp_i_arid", 32'(f_arid), 32'd0);
    step();
    arready = 1'b0;
    r_beat(4'd0, 32'hE0, 1'b1, 2'b00);
    step();
    r_beat(4'd1, 32'hE1, 1'b1, 2'b00);
    step();
    r_idle();
    p_i_req = 1'b1; p_d_req = 1'b1;
    settle();
    check("t2_fp_d_again", 32'(f_d_gnt), 32'd1);
    check("t2_fp_i_again_held", 32'(f_i_gnt), 32'd0);
    step();
    p_i_req = 1'b0; p_d_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
